// File: rtl/mac_acc_reader_if.sv
// Byte-stream handshake bundle between mac_acc_reader and the result sink.
// master drives data/valid/last, slave returns ready.
interface mac_acc_reader_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/mac_acc_reader.sv
// mac_acc_reader: captures the final MAC accumulator value, clears the
// accumulator and streams the result LSB-first as 8-bit beats.
// Optional build macro ACC_READER_SAT_EN: saturate the captured value to
// 16 bits and send 2 beats instead of the raw 22-bit value in 3 beats.
module mac_acc_reader (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [21:0]             acc,
    input  logic                    acc_done,
    output logic                    acc_clr,
    mac_acc_reader_if.master        tx,
    output logic                    busy,
    output logic                    overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

`ifdef ACC_READER_SAT_EN
    localparam logic [1:0] LAST_BEAT = 2'd1;
`else
    localparam logic [1:0] LAST_BEAT = 2'd2;
`endif

    state_t      state;
    logic [23:0] shift;
    logic [1:0]  cnt;
    logic        valid_q;
    logic        last_q;

    logic [23:0] cap_word;
    logic        handshake;
    logic        final_hs;
    logic        load;
    logic        drop;

    // Low byte of the shift register is always the beat on the wire.
    assign tx.tx_data  = shift[7:0];
    assign tx.tx_valid = valid_q;
    assign tx.tx_last  = last_q;

    // Value to be captured from the accumulator this cycle.
    always_comb begin
`ifdef ACC_READER_SAT_EN
        if (acc > 22'h00FFFF) begin
            cap_word = 24'h00FFFF;
        end else begin
            cap_word = {8'h00, acc[15:0]};
        end
`else
        cap_word = {2'b00, acc};
`endif
    end

    // Handshake decode; a capture is legal when idle or on the final beat.
    always_comb begin
        handshake = valid_q && tx.tx_ready;
        final_hs  = handshake && (cnt == 2'd0);
        load      = acc_done && ((state == IDLE) || final_hs);
        drop      = acc_done && (state == SEND) && !final_hs;
    end

    // Read-out FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift   <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            acc_clr <= load;
            if (drop) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= SEND;
                        shift   <= cap_word;
                        cnt     <= LAST_BEAT;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    if (load) begin
                        // final beat accepted with a new result pending:
                        // reload without an idle bubble
                        shift   <= cap_word;
                        cnt     <= LAST_BEAT;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        busy    <= 1'b1;
                    end else if (final_hs) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (handshake) begin
                        shift   <= shift >> 8;
                        cnt     <= cnt - 2'd1;
                        last_q  <= (cnt == 2'd1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
